// File: rtl/dct_pkg.sv
// Shared definitions for the dct_2d frame sequencer.
//   BLK / PIX_W / COEF_W : block edge, pixel width, coefficient width
//   dct_coef_t           : signed coefficient as produced by dct_2d
//   rd_state_t           : read-side sequencer states
//   coef_tag_t           : position tag attached to each outgoing coefficient
//   level_shift()        : unsigned pixel -> signed (p - 128)
package dct_pkg;

  localparam int unsigned BLK       = 8;
  localparam int unsigned PIX_W     = 8;
  localparam int unsigned COEF_W    = 15;
  localparam int unsigned TAG_BLK_W = 16;

  typedef logic signed [COEF_W-1:0] dct_coef_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RDY = 2'd1,
    ROW      = 2'd2,
    DRAIN    = 2'd3
  } rd_state_t;

  typedef struct packed {
    logic [2:0]           u;
    logic [2:0]           v;
    logic [TAG_BLK_W-1:0] blk;
    logic                 last;
  } coef_tag_t;

  // Subtracting 128 from an 8-bit unsigned value is just an MSB flip.
  function automatic logic [PIX_W-1:0] level_shift(input logic [PIX_W-1:0] p);
    return {~p[PIX_W-1], p[PIX_W-2:0]};
  endfunction

endpackage

// File: rtl/dct_blk_addr_gen.sv
// Block-raster pixel address generator.
// Walks an IMG_W x IMG_H frame as 8x8 blocks in raster block order, each
// block row by row, producing y*IMG_W + x without a multiplier.
//   clk, rst     : clock, synchronous active-high reset
//   clear_i      : return all counters to the first pixel of the frame
//   step_i       : advance one pixel (column, then row, then block)
//   addr_o       : current pixel address
//   row_end_o    : current pixel is column 7 of its block row
//   frame_end_o  : current pixel is the final pixel of the frame
module dct_blk_addr_gen
  import dct_pkg::*;
#(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              row_end_o,
  output logic              frame_end_o
);

  localparam int unsigned NBX  = IMG_W / BLK;
  localparam int unsigned NBY  = IMG_H / BLK;
  localparam int unsigned BX_W = (NBX > 1) ? $clog2(NBX) : 1;
  localparam int unsigned BY_W = (NBY > 1) ? $clog2(NBY) : 1;

  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] BLK_STEP  = ADDR_W'(BLK);
  localparam logic [ADDR_W-1:0] BAND_STEP = ADDR_W'(BLK * IMG_W);

  logic [2:0]        c_q, c_d, r_q, r_d;
  logic [BX_W-1:0]   bx_q, bx_d;
  logic [BY_W-1:0]   by_q, by_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] blk_base_q, blk_base_d;
  logic [ADDR_W-1:0] band_base_q, band_base_d;

  logic bx_last, by_last;

  assign bx_last = (bx_q == BX_W'(NBX - 1));
  assign by_last = (by_q == BY_W'(NBY - 1));

  assign addr_o      = addr_q;
  assign row_end_o   = (c_q == 3'd7);
  assign frame_end_o = (c_q == 3'd7) && (r_q == 3'd7) && bx_last && by_last;

  // Three base registers (band, block, row) let every step be an add of a
  // constant; the address register always holds row_base + c.
  always_comb begin
    c_d         = c_q;
    r_d         = r_q;
    bx_d        = bx_q;
    by_d        = by_q;
    addr_d      = addr_q;
    row_base_d  = row_base_q;
    blk_base_d  = blk_base_q;
    band_base_d = band_base_q;
    if (clear_i) begin
      c_d         = '0;
      r_d         = '0;
      bx_d        = '0;
      by_d        = '0;
      addr_d      = '0;
      row_base_d  = '0;
      blk_base_d  = '0;
      band_base_d = '0;
    end else if (step_i) begin
      if (c_q != 3'd7) begin
        c_d    = c_q + 3'd1;
        addr_d = addr_q + ADDR_W'(1);
      end else begin
        c_d = '0;
        if (r_q != 3'd7) begin
          r_d        = r_q + 3'd1;
          row_base_d = row_base_q + ROW_STEP;
          addr_d     = row_base_q + ROW_STEP;
        end else begin
          r_d = '0;
          if (!bx_last) begin
            bx_d       = bx_q + BX_W'(1);
            blk_base_d = blk_base_q + BLK_STEP;
            row_base_d = blk_base_q + BLK_STEP;
            addr_d     = blk_base_q + BLK_STEP;
          end else begin
            bx_d = '0;
            if (!by_last) begin
              by_d        = by_q + BY_W'(1);
              band_base_d = band_base_q + BAND_STEP;
              blk_base_d  = band_base_q + BAND_STEP;
              row_base_d  = band_base_q + BAND_STEP;
              addr_d      = band_base_q + BAND_STEP;
            end else begin
              by_d        = '0;
              band_base_d = '0;
              blk_base_d  = '0;
              row_base_d  = '0;
              addr_d      = '0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q         <= '0;
      r_q         <= '0;
      bx_q        <= '0;
      by_q        <= '0;
      addr_q      <= '0;
      row_base_q  <= '0;
      blk_base_q  <= '0;
      band_base_q <= '0;
    end else begin
      c_q         <= c_d;
      r_q         <= r_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      addr_q      <= addr_d;
      row_base_q  <= row_base_d;
      blk_base_q  <= blk_base_d;
      band_base_q <= band_base_d;
    end
  end

endmodule

// File: rtl/dct_frame_ctrl.sv
// Frame-level sequencer for the dct_2d core.
// Reads a greyscale frame block by block from a 1-cycle-latency memory,
// level-shifts each pixel and feeds dct_2d in 8-pixel row bursts gated by
// dct_rdy_out; tags coefficients leaving the core with (blk,u,v) and pulses
// done after the last coefficient of the frame transfers.
//   clk, rst                    : clock, synchronous active-high reset
//   start / busy / done         : frame control and status
//   mem_rd, mem_addr, mem_rdata : pixel memory read port
//   dct_rdy_out, dct_ena_in, dct_in           : feed to dct_2d
//   dct_ena_out, dct_out, dct_rdy_in          : coefficients from dct_2d
//   coef_valid, coef, coef_u, coef_v, coef_blk, coef_last, coef_ready
//                               : tagged coefficient stream downstream
module dct_frame_ctrl
  import dct_pkg::*;
#(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 16,
  parameter int BLK_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              dct_rdy_out,
  output logic              dct_ena_in,
  output logic [7:0]        dct_in,
  input  logic              dct_ena_out,
  input  logic [14:0]       dct_out,
  output logic              dct_rdy_in,
  output logic              coef_valid,
  output logic [14:0]       coef,
  output logic [2:0]        coef_u,
  output logic [2:0]        coef_v,
  output logic [BLK_W-1:0]  coef_blk,
  output logic              coef_last,
  input  logic              coef_ready
);

  localparam int unsigned NBLK = (IMG_W / BLK) * (IMG_H / BLK);

  rd_state_t        state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ena_q;
  logic [2:0]       out_u_q, out_u_d, out_v_q, out_v_d;
  logic [BLK_W-1:0] out_blk_q, out_blk_d;
  coef_tag_t        tag;

  logic gen_clear, gen_step, row_end, frame_end, xfer;

  dct_blk_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (gen_clear),
    .step_i     (gen_step),
    .addr_o     (mem_addr),
    .row_end_o  (row_end),
    .frame_end_o(frame_end)
  );

  assign xfer = dct_ena_out && coef_ready;

  always_comb begin
    tag      = '0;
    tag.u    = out_u_q;
    tag.v    = out_v_q;
    tag.blk  = TAG_BLK_W'(out_blk_q);
    tag.last = (out_blk_q == BLK_W'(NBLK - 1)) && (&out_u_q) && (&out_v_q);
  end

  // Read sequencer. Completion is driven by the output side, so the
  // last-coefficient transfer overrides whatever the read side is doing.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    gen_clear = 1'b0;
    gen_step  = 1'b0;
    case (state_q)
      IDLE: begin
        // done_q high means this is the completion cycle: start is ignored.
        if (start && !done_q) begin
          state_d   = WAIT_RDY;
          busy_d    = 1'b1;
          gen_clear = 1'b1;
        end
      end
      WAIT_RDY: if (dct_rdy_out) state_d = ROW;
      ROW: begin
        gen_step = 1'b1;
        if (row_end) state_d = frame_end ? DRAIN : WAIT_RDY;
      end
      DRAIN: ;
      default: state_d = IDLE;
    endcase
    if (busy_q && xfer && tag.last) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  // dct_2d emits column-major: v runs fastest, then u, then block.
  always_comb begin
    out_u_d   = out_u_q;
    out_v_d   = out_v_q;
    out_blk_d = out_blk_q;
    if (xfer) begin
      out_v_d = out_v_q + 3'd1;
      if (&out_v_q) begin
        out_u_d = out_u_q + 3'd1;
        if (&out_u_q) out_blk_d = tag.last ? '0 : out_blk_q + BLK_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ena_q     <= 1'b0;
      out_u_q   <= '0;
      out_v_q   <= '0;
      out_blk_q <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ena_q     <= mem_rd;
      out_u_q   <= out_u_d;
      out_v_q   <= out_v_d;
      out_blk_q <= out_blk_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign mem_rd = (state_q == ROW);

  // Read data arrives the cycle after mem_rd, aligned with the registered
  // strobe; the shifted pixel is forced to zero outside a burst.
  assign dct_ena_in = ena_q;
  assign dct_in     = ena_q ? level_shift(mem_rdata) : '0;

  assign dct_rdy_in = coef_ready;
  assign coef_valid = dct_ena_out;
  assign coef       = dct_out;
  assign coef_u     = tag.u;
  assign coef_v     = tag.v;
  assign coef_blk   = BLK_W'(tag.blk);
  assign coef_last  = tag.last;

endmodule

// File: tb/tb_dct_frame_ctrl.sv
module tb_dct_frame_ctrl;

  localparam int W     = 16;
  localparam int H     = 8;
  localparam int NPIX  = W * H;
  localparam int NBLK  = (W / 8) * (H / 8);
  localparam int NCOEF = NBLK * 64;

  logic        clk, rst, start, busy, done, mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        dct_rdy_out, dct_ena_in;
  logic [7:0]  dct_in;
  logic        dct_ena_out;
  logic [14:0] dct_out;
  logic        dct_rdy_in, coef_valid;
  logic [14:0] coef;
  logic [2:0]  coef_u, coef_v;
  logic [11:0] coef_blk;
  logic        coef_last, coef_ready;

  int n_cmp, n_err;
  logic [7:0] mem [NPIX];
  int addr_exp[$];
  int obs_in[3];
  int ready_mode;     // 0: always ready, 1: toggle, 2: random
  int in_cnt, pend;
  bit took;

  dct_frame_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(16), .BLK_W(12)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .dct_rdy_out(dct_rdy_out), .dct_ena_in(dct_ena_in), .dct_in(dct_in),
    .dct_ena_out(dct_ena_out), .dct_out(dct_out), .dct_rdy_in(dct_rdy_in),
    .coef_valid(coef_valid), .coef(coef), .coef_u(coef_u), .coef_v(coef_v),
    .coef_blk(coef_blk), .coef_last(coef_last), .coef_ready(coef_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pixel memory with one cycle read latency.
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  // Stand-in for dct_2d: once 64 pixels of a block have entered, it owes
  // 64 coefficients, which it offers with random values under coef_ready.
  always @(posedge clk) begin
    took = dct_ena_out && coef_ready;
    if (rst) begin
      in_cnt = 0;
      pend   = 0;
    end else begin
      if (dct_ena_in) begin
        in_cnt++;
        if (in_cnt % 64 == 0) pend += 64;
      end
      if (took) pend--;
    end
  end

  always @(negedge clk) begin
    if (rst || pend == 0) dct_ena_out = 1'b0;
    else begin
      if (!dct_ena_out || took) dct_out = 15'($urandom);
      dct_ena_out = 1'b1;
    end
  end

  // Runs one frame from start, checking the read address order, the fed
  // pixel stream, burst shape, coefficient tags and completion.
  task automatic run_frame(input int stall_at, input int dup_start_at,
                           input bit start_at_done);
    int ai = 0, ei = 0, ki = 0, run = 0, dones = 0, post = 0;
    int stall_left = 0, sidx = 0, late_bad = 0, exp_in;
    bit stalled = 0, start_next = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      start = (cyc == 0) || (cyc == dup_start_at) || start_next;
      start_next = 0;
      case (ready_mode)
        0:       coef_ready = 1'b1;
        1:       coef_ready = (cyc % 2 == 0);
        default: coef_ready = 1'($urandom_range(0, 1));
      endcase
      if (stall_at >= 0 && !stalled && ai >= stall_at) begin
        stalled = 1; stall_left = 20; sidx = 0;
      end
      dct_rdy_out = (stall_left == 0);
      if (stall_left > 0) begin stall_left--; sidx++; end
      #2;
      if (cyc == 1) begin
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL busy_after_start got %b want 1", busy); end
      end
      if (!dct_rdy_out && sidx > 10) begin
        n_cmp++;
        if (mem_rd !== 1'b0 || dct_ena_in !== 1'b0) begin
          n_err++; $display("FAIL stall_quiet mem_rd=%b ena_in=%b want 0/0", mem_rd, dct_ena_in);
        end
      end
      if (mem_rd) begin
        n_cmp++;
        if (ai >= NPIX) begin n_err++; $display("FAIL extra_read addr=%0d", mem_addr); end
        else if (int'(mem_addr) !== addr_exp[ai]) begin
          n_err++; $display("FAIL mem_addr idx=%0d got %0d want %0d", ai, mem_addr, addr_exp[ai]);
        end
        ai++;
      end
      if (dct_ena_in) begin
        run++;
        if (ei < NPIX) begin
          exp_in = int'(mem[addr_exp[ei]]) - 128;
          if (ei < 3) obs_in[ei] = int'($signed(dct_in));
          n_cmp++;
          if (int'($signed(dct_in)) !== exp_in) begin
            n_err++; $display("FAIL dct_in idx=%0d got %0d want %0d", ei, $signed(dct_in), exp_in);
          end
        end
        ei++;
      end else if (run > 0) begin
        n_cmp++;
        if (run != 8) begin n_err++; $display("FAIL burst_len got %0d want 8", run); end
        run = 0;
      end
      n_cmp++;
      if (dct_rdy_in !== coef_ready || coef_valid !== dct_ena_out) begin
        n_err++; $display("FAIL passthru rdy_in=%b valid=%b want %b/%b", dct_rdy_in, coef_valid, coef_ready, dct_ena_out);
      end
      if (dct_ena_out && coef_ready) begin
        n_cmp++;
        if (ki >= NCOEF) begin n_err++; $display("FAIL extra_coef k=%0d", ki); end
        else if ({coef_blk, coef_u, coef_v, coef_last, coef} !==
                 {12'(ki / 64), 3'((ki % 64) / 8), 3'(ki % 8), ki == NCOEF - 1, dct_out}) begin
          n_err++;
          $display("FAIL coef_tag k=%0d got blk%0d u%0d v%0d last%b coef%0h want blk%0d u%0d v%0d last%b coef%0h",
                   ki, coef_blk, coef_u, coef_v, coef_last, coef,
                   ki / 64, (ki % 64) / 8, ki % 8, ki == NCOEF - 1, dct_out);
        end
        if (start_at_done && ki == NCOEF - 1) start_next = 1;
        ki++;
      end
      if (dones > 0) begin
        post++;
        if (busy !== 1'b0 || mem_rd !== 1'b0) late_bad++;
      end
      if (done) begin
        dones++;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL busy_at_done got %b want 0", busy); end
      end
      if (post >= 20) break;
    end
    n_cmp++;
    if (ai != NPIX || ei != NPIX || ki != NCOEF) begin
      n_err++; $display("FAIL frame_counts reads=%0d fed=%0d coefs=%0d want %0d/%0d/%0d", ai, ei, ki, NPIX, NPIX, NCOEF);
    end
    n_cmp++;
    if (dones != 1) begin n_err++; $display("FAIL done_count got %0d want 1", dones); end
    n_cmp++;
    if (late_bad != 0) begin n_err++; $display("FAIL idle_after_done bad_cycles=%0d want 0", late_bad); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    n_cmp++;
    if ({busy, done, mem_rd, mem_addr, dct_ena_in, dct_in, coef_u, coef_v, coef_blk} !== '0) begin
      n_err++; $display("FAIL reset_state busy=%b done=%b rd=%b addr=%0d ena=%b in=%0d u=%0d v=%0d blk=%0d want all 0",
                        busy, done, mem_rd, mem_addr, dct_ena_in, dct_in, coef_u, coef_v, coef_blk);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    for (int a = 0; a < NPIX; a++) mem[a] = 8'((a % W) * 16 + a / W);
    ready_mode = 0;
    run_frame(-1, -1, 0);
  endtask

  task automatic test_level_shift();
    for (int a = 0; a < NPIX; a++) mem[a] = 8'($urandom);
    mem[0] = 8'd0; mem[1] = 8'd128; mem[2] = 8'd255;
    ready_mode = 0;
    run_frame(-1, -1, 0);
    n_cmp++;
    if (obs_in[0] != -128 || obs_in[1] != 0 || obs_in[2] != 127) begin
      n_err++; $display("FAIL level_shift got %0d %0d %0d want -128 0 127", obs_in[0], obs_in[1], obs_in[2]);
    end
  endtask

  task automatic test_stall();
    for (int a = 0; a < NPIX; a++) mem[a] = 8'($urandom);
    ready_mode = 2;
    run_frame(20, -1, 0);
  endtask

  task automatic test_ready_toggle();
    ready_mode = 1;
    run_frame(-1, -1, 1);
  endtask

  task automatic test_start_while_busy();
    ready_mode = 2;
    run_frame(-1, 40, 0);
  endtask

  task automatic test_abort();
    int ai = 0, bad = 0;
    ready_mode = 0;
    dct_rdy_out = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 1000 && ai < 100; cyc++) begin
      #2;
      if (mem_rd) ai++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, mem_rd, mem_addr, dct_ena_in, dct_in, coef_u, coef_v, coef_blk} !== '0) begin
      n_err++; $display("FAIL abort_state busy=%b done=%b rd=%b addr=%0d ena=%b in=%0d u=%0d v=%0d blk=%0d want all 0",
                        busy, done, mem_rd, mem_addr, dct_ena_in, dct_in, coef_u, coef_v, coef_blk);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (300) begin
      @(negedge clk); #2;
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL abort_quiet bad_cycles=%0d want 0", bad); end
    for (int a = 0; a < NPIX; a++) mem[a] = 8'($urandom);
    ready_mode = 2;
    run_frame(-1, -1, 0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    start = 1'b0; coef_ready = 1'b1; dct_rdy_out = 1'b1; rst = 1'b1;
    dct_ena_out = 1'b0; dct_out = '0; ready_mode = 0;
    for (int by = 0; by < H / 8; by++)
      for (int bx = 0; bx < W / 8; bx++)
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++)
            addr_exp.push_back((by * 8 + r) * W + bx * 8 + c);
    test_reset();
    test_basic();
    test_level_shift();
    test_stall();
    test_ready_toggle();
    test_start_while_busy();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dct_frame_ctrl.md
Name: dct_frame_ctrl

Overview:
Frame-level sequencer for the dct_2d core. On start it walks an IMG_W x IMG_H 8-bit greyscale frame in 8x8 blocks, raster block order, reading pixels from a 1-cycle-latency memory. It level-shifts each pixel to signed and feeds dct_2d one 8-pixel row burst at a time under the core's rdy_out handshake. It also tags each coefficient leaving the core with block index and (u,v) position for the downstream quantiser/zigzag stage, and reports frame completion.

Parameters:
IMG_W, 16, frame width in pixels; multiple of 8, >= 8
IMG_H, 8, frame height in pixels; multiple of 8, >= 8
ADDR_W, 16, pixel memory address width; must satisfy IMG_W*IMG_H <= 2**ADDR_W
BLK_W, 12, block index width; must satisfy (IMG_W/8)*(IMG_H/8) <= 2**BLK_W

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  pulse; begins a frame when idle
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse after the last coefficient of the frame transfers
mem_rd  out  1  pixel read strobe
mem_addr  out  ADDR_W  pixel address = y*IMG_W + x
mem_rdata  in  8  unsigned pixel, valid the cycle after mem_rd
dct_rdy_out  in  1  dct_2d can accept a row burst
dct_ena_in  out  1  dct_2d input valid; held for 8 contiguous cycles per row
dct_in  out  8  signed level-shifted pixel
dct_ena_out  in  1  dct_2d coefficient valid
dct_out  in  15  signed coefficient from dct_2d
dct_rdy_in  out  1  downstream ready back to dct_2d; equals coef_ready, combinational
coef_valid  out  1  equals dct_ena_out
coef  out  15  equals dct_out
coef_u  out  3  horizontal frequency index
coef_v  out  3  vertical frequency index
coef_blk  out  BLK_W  block index of this coefficient, raster order from 0
coef_last  out  1  last coefficient of the frame (blk = last, u = 7, v = 7)
coef_ready  in  1  downstream accepts coefficient

Behaviour:
- Reset: busy=0, done=0, mem_rd=0, mem_addr=0, dct_ena_in=0, dct_in=0. All counters (bx, by, r, c, out_u, out_v, out_blk) are 0 and the FSM is IDLE. Reset mid-frame aborts with no done pulse. dct_2d shares rst.
- Read FSM:
  - IDLE: start -> WAIT_RDY, busy=1. start while busy is ignored.
  - WAIT_RDY: dct_rdy_out sampled high -> ROW.
  - ROW: 8 consecutive cycles with mem_rd=1 and c=0..7, addr = (by*8+r)*IMG_W + bx*8 + c. After c=7:
    - r<7: r++, go to WAIT_RDY.
    - r=7: r=0, advance bx (wrap to 0 with by++). After the last block -> DRAIN.
  - DRAIN: waits for the output side to finish, then goes to IDLE.
- Feed path: dct_ena_in and dct_in are registered one cycle after mem_rd, so 8 contiguous valid cycles per row. dct_in = mem_rdata - 128, i.e. {~mem_rdata[7], mem_rdata[6:0]}. Examples: 0 -> -128, 128 -> 0, 255 -> 127.
- Addresses are computed incrementally (row base + offset). No multiplier.
- Output side:
  - A coefficient transfers when dct_ena_out && coef_ready.
  - dct_2d emits column-major, so out_v increments first 0..7, then out_u increments. After (7,7), out_blk increments.
  - Counters advance only on transfer; ena_out without ready holds the tags.
- Completion: the transfer with coef_last=1 causes done=1 and busy=0 on the next cycle, with the FSM back in IDLE. A start arriving in the same cycle as done is ignored.
- The input side may run ahead of the output by as many blocks as dct_2d buffers; flow control comes only from dct_rdy_out.

Decomposition:
- dct_pkg holds:
  - constants BLK=8, PIX_W=8, COEF_W=15
  - typedef dct_coef_t (signed [14:0])
  - typedef enum rd_state_t {IDLE, WAIT_RDY, ROW, DRAIN}
  - a struct coef_tag_t {u, v, blk, last}
- Sub-module dct_blk_addr_gen: bx/by/r/c counters and incremental address, with advance/last outputs.

Test Plan:
- 16x8 frame with pixel[y][x] = x*16 + y, dct_rdy_out=1 and coef_ready=1 held:
  - mem_addr order is 0..7, 16..23, ... 112..119, then 8..15, 24..31, ...
  - dct_in at row 0 of block 0 is -128, -112, ..., -16.
- Level shift: pixels 0, 128, 255 -> dct_in -128, 0, 127. dct_ena_in is high for exactly 8 contiguous cycles per row.
- Drop dct_rdy_out for 20 cycles mid-block: no mem_rd and no dct_ena_in during the stall; the burst resumes at the next row with the correct address.
- Toggle coef_ready every other cycle: dct_rdy_in follows it. Tags go (u0,v0), (u0,v1) ... (u0,v7), (u1,v0) ... with no skips. coef_blk steps 0 -> 1. coef_last appears only on block 1 (7,7). done pulses exactly once.
- Assert rst in the middle of block 1: all outputs return to reset values next cycle and no done pulse. A new start rereads from address 0.
- Pulse start while busy: no effect on the address sequence and a single done.
